// File: rtl/fp_mul_sequencer_pkg.sv
// Shared types for the lane multiply sequencer.
// Thread tags, pipeline ids, FSM states.
package fp_mul_sequencer_pkg;

  typedef logic [1:0] local_thread_idx_t;

  typedef enum logic [1:0] {
    PIPE_MEM,
    PIPE_SCALAR1,
    PIPE_SCALAR2,
    PIPE_VECTOR
  } pipeline_sel_t;

  typedef enum logic [1:0] {
    MUL_IDLE,
    MUL_BUSY,
    MUL_DONE
  } mul_seq_state_t;

  localparam int MUL_SEQ_ITERATIONS = 17;

  // 32 -> 34 bit so an unsigned operand stays positive in Booth
  function automatic logic [33:0] ext34(
    input logic        s,
    input logic [31:0] v
  );
    return {{2{s & v[31]}}, v};
  endfunction

endpackage

// File: rtl/fp_mul_sequencer_booth_radix4_digit.sv
// Radix-4 Booth digit recoder.
// Maps a 3-bit window to 0, +-A or +-2A.
module booth_radix4_digit (
  input  logic [2:0]  window_i,
  input  logic [33:0] mcand_i,
  output logic [35:0] pp_o
);

  logic [35:0] a1;
  logic [35:0] a2;

  assign a1 = {{2{mcand_i[33]}}, mcand_i};
  assign a2 = {mcand_i[33], mcand_i, 1'b0};

  always_comb begin
    pp_o = '0;
    unique case (window_i)
      3'b001, 3'b010: pp_o = a1;
      3'b011:         pp_o = a2;
      3'b100:         pp_o = -a2;
      3'b101, 3'b110: pp_o = -a1;
      default:        pp_o = '0;
    endcase
  end

endmodule

// File: rtl/fp_mul_sequencer.sv
// Iterative exact 32x32 multiplier, radix-4 Booth,
// one digit per cycle, valid/ready on both sides.
module fp_mul_sequencer
  import fp_mul_sequencer_pkg::*;
#(
  parameter int ITERATIONS = MUL_SEQ_ITERATIONS
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_signed_i,
  input  logic [31:0]       req_multiplicand_i,
  input  logic [31:0]       req_multiplier_i,
  input  local_thread_idx_t req_thread_idx_i,
  input  logic              wb_rollback_en_i,
  input  local_thread_idx_t wb_rollback_thread_idx_i,
  input  pipeline_sel_t     wb_rollback_pipeline_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [63:0]       resp_product_o,
  output local_thread_idx_t resp_thread_idx_o
);

  localparam logic [4:0] LAST = 5'(ITERATIONS - 1);

  mul_seq_state_t    state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [35:0]       acc_q, acc_d;
  logic [33:0]       mr_q, mr_d;
  logic              bm1_q, bm1_d;
  logic [33:0]       mcand_q, mcand_d;
  local_thread_idx_t tag_q, tag_d;

  logic [35:0] pp;
  logic [35:0] sum;
  logic        rb_mem;
  logic        rb_hit;
  logic        rb_hit_req;

  booth_radix4_digit u_digit (
    .window_i ({mr_q[1:0], bm1_q}),
    .mcand_i  (mcand_q),
    .pp_o     (pp)
  );

  assign sum        = acc_q + pp;
  assign rb_mem     = wb_rollback_en_i
                    && wb_rollback_pipeline_i == PIPE_MEM;
  assign rb_hit     = rb_mem
                    && wb_rollback_thread_idx_i == tag_q;
  assign rb_hit_req = rb_mem
                    && wb_rollback_thread_idx_i == req_thread_idx_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= MUL_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mr_q    <= '0;
      bm1_q   <= 1'b0;
      mcand_q <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mr_q    <= mr_d;
      bm1_q   <= bm1_d;
      mcand_q <= mcand_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mr_d    = mr_q;
    bm1_d   = bm1_q;
    mcand_d = mcand_q;
    tag_d   = tag_q;
    unique case (state_q)
      MUL_IDLE: begin
        if (req_valid_i && !rb_hit_req) begin
          state_d = MUL_BUSY;
          cnt_d   = LAST;
          acc_d   = '0;
          bm1_d   = 1'b0;
          mr_d    = ext34(req_signed_i, req_multiplier_i);
          mcand_d = ext34(req_signed_i, req_multiplicand_i);
          tag_d   = req_thread_idx_i;
        end
      end
      MUL_BUSY: begin
        if (rb_hit) begin
          state_d = MUL_IDLE;
        end else begin
          // {acc,mr} shifts right by 2 as one 70-bit register
          acc_d = {{2{sum[35]}}, sum[35:2]};
          mr_d  = {sum[1:0], mr_q[33:2]};
          bm1_d = mr_q[1];
          if (cnt_q == '0) state_d = MUL_DONE;
          else             cnt_d   = cnt_q - 5'd1;
        end
      end
      MUL_DONE: begin
        if (rb_hit || resp_ready_i) state_d = MUL_IDLE;
      end
      default: state_d = MUL_IDLE;
    endcase
  end

  assign req_ready_o       = state_q == MUL_IDLE;
  assign resp_valid_o      = state_q == MUL_DONE;
  assign resp_product_o    = {acc_q[29:0], mr_q};
  assign resp_thread_idx_o = tag_q;

endmodule
